// File: rtl/reg_writeback.sv
// reg_writeback: write-side master for the register file.
// Merges ALU results and buffered memory-load results onto the single
// regfile write port. ALU results normally win. A starvation counter
// forces a FIFO pop (and stalls the ALU) once loads have been preempted
// STARVE_LIMIT times in a row. The block also reports PC writes and RAW
// hazards against pending writes.
//
// Ports:
//   clock, reset_n                 rising-edge clock, async active-low reset
//   alu_valid/alu_sel/alu_data     ALU result input (no backpressure)
//   alu_flags_we/alu_flags         NZCV update request
//   alu_stall                      ALU must not present a result this cycle
//   ld_valid/ld_ready/ld_sel/ld_data  load-result handshake into the FIFO
//   in_enable/sel_in/in_reg        registered regfile write port
//   flags_in                       registered, held NZCV to the regfile
//   pc_written                     registered pulse for writes to r15
//   hz_sel/hz_pending              decode read register / pending-write hit
module reg_writeback #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        alu_valid,
  input  logic [3:0]  alu_sel,
  input  logic [31:0] alu_data,
  input  logic        alu_flags_we,
  input  logic [3:0]  alu_flags,
  output logic        alu_stall,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [3:0]  ld_sel,
  input  logic [31:0] ld_data,
  output logic        in_enable,
  output logic [3:0]  sel_in,
  output logic [31:0] in_reg,
  output logic [3:0]  flags_in,
  output logic        pc_written,
  input  logic [3:0]  hz_sel,
  output logic        hz_pending
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [3:0]    mem_sel  [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] starve_cnt;
  logic          empty, full, push, pop, alu_win;
  logic [3:0]    head_sel;
  logic [31:0]   head_data;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign ld_ready  = !full;
  assign alu_stall = (starve_cnt == CW'(STARVE_LIMIT)) && !empty;

  assign push      = ld_valid && ld_ready;
  assign alu_win   = alu_valid && !alu_stall;
  // A stall cycle always pops. An ALU result offered during a stall is dropped.
  assign pop       = !empty && (alu_stall || !alu_valid);

  assign head_sel  = mem_sel[rd_ptr[AW-1:0]];
  assign head_data = mem_data[rd_ptr[AW-1:0]];

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_sel[wr_ptr[AW-1:0]]  <= ld_sel;
      mem_data[wr_ptr[AW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      in_enable  <= 1'b0;
      sel_in     <= '0;
      in_reg     <= '0;
      flags_in   <= '0;
      pc_written <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (pop || empty)
        starve_cnt <= '0;
      else if (alu_win && (starve_cnt != CW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + CW'(1);

      if (alu_win) begin
        in_enable  <= 1'b1;
        sel_in     <= alu_sel;
        in_reg     <= alu_data;
        pc_written <= (alu_sel == 4'hF);
      end else if (pop) begin
        in_enable  <= 1'b1;
        sel_in     <= head_sel;
        in_reg     <= head_data;
        pc_written <= (head_sel == 4'hF);
      end else begin
        in_enable  <= 1'b0;
        pc_written <= 1'b0;
      end

      if (alu_flags_we) flags_in <= alu_flags;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [AW-1:0] offset;
    hz_pending = in_enable && (sel_in == hz_sel);
    offset     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = AW'(i) - rd_ptr[AW-1:0];
      if (({1'b0, offset} < count) && (mem_sel[i] == hz_sel))
        hz_pending = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed self-checking bench for reg_writeback
// (DEPTH=4, STARVE_LIMIT=3). Inputs change 1 time unit after posedge.
// Registered outputs are checked after the next posedge. Combinational
// outputs are checked 1 time unit after the inputs settle.
module tb_reg_writeback;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [3:0]  alu_sel;
  logic [31:0] alu_data;
  logic        alu_flags_we;
  logic [3:0]  alu_flags;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_sel;
  logic [31:0] ld_data;
  logic        in_enable;
  logic [3:0]  sel_in;
  logic [31:0] in_reg;
  logic [3:0]  flags_in;
  logic        pc_written;
  logic [3:0]  hz_sel;
  logic        hz_pending;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  reg_writeback #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_data(alu_data),
    .alu_flags_we(alu_flags_we), .alu_flags(alu_flags), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_data(ld_data),
    .in_enable(in_enable), .sel_in(sel_in), .in_reg(in_reg),
    .flags_in(flags_in), .pc_written(pc_written),
    .hz_sel(hz_sel), .hz_pending(hz_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // The ALU must never present a result in a stall cycle.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      checks++;
      assert (!(alu_valid === 1'b1 && alu_stall === 1'b1)) else begin
        errors++;
        $error("FAIL alu_valid_during_stall: observed 1 expected 0");
      end
    end
  end

  initial begin
    reset_n = 1'b0; alu_valid = 1'b0; alu_sel = '0; alu_data = '0;
    alu_flags_we = 1'b0; alu_flags = '0; ld_valid = 1'b0; ld_sel = '0;
    ld_data = '0; hz_sel = '0;
    tick(); tick();
    chk("rst_in_enable", 32'(in_enable), 32'd0);
    chk("rst_sel_in", 32'(sel_in), 32'd0);
    chk("rst_in_reg", in_reg, 32'd0);
    chk("rst_flags_in", 32'(flags_in), 32'd0);
    chk("rst_pc_written", 32'(pc_written), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_alu_stall", 32'(alu_stall), 32'd0);
    chk("rst_hz_pending", 32'(hz_pending), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single ALU write, one-cycle latency.
    alu_valid = 1'b1; alu_sel = 4'd1; alu_data = 32'h87654321;
    tick();
    alu_valid = 1'b0; hz_sel = 4'd1;
    #1;
    chk("alu_in_enable", 32'(in_enable), 32'd1);
    chk("alu_sel_in", 32'(sel_in), 32'd1);
    chk("alu_in_reg", in_reg, 32'h87654321);
    chk("alu_pc_written", 32'(pc_written), 32'd0);
    chk("alu_hz_out", 32'(hz_pending), 32'd1);
    tick();
    chk("idle_in_enable", 32'(in_enable), 32'd0);

    // Load into an empty FIFO: queued at push, written one cycle later.
    ld_valid = 1'b1; ld_sel = 4'd2; ld_data = 32'h12345678; hz_sel = 4'd2;
    #1;
    chk("ld_hz_before", 32'(hz_pending), 32'd0);
    tick();
    ld_valid = 1'b0;
    #1;
    chk("ld_push_no_write", 32'(in_enable), 32'd0);
    chk("ld_hz_queued", 32'(hz_pending), 32'd1);
    tick();
    chk("ld_in_enable", 32'(in_enable), 32'd1);
    chk("ld_sel_in", 32'(sel_in), 32'd2);
    chk("ld_in_reg", in_reg, 32'h12345678);
    chk("ld_hz_out", 32'(hz_pending), 32'd1);
    tick();
    chk("ld_done_in_enable", 32'(in_enable), 32'd0);
    chk("ld_done_hz", 32'(hz_pending), 32'd0);

    // Starvation: one queued load, ALU busy; the stall lands in cycle 4.
    ld_valid = 1'b1; ld_sel = 4'd3; ld_data = 32'hAAAA0003;
    tick();
    ld_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      alu_valid = (k != 4); alu_sel = 4'd8; alu_data = 32'(k);
      #1;
      chk($sformatf("starve_stall_c%0d", k), 32'(alu_stall), (k == 4) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("starve_sel_c%0d", k), 32'(sel_in), (k == 4) ? 32'd3 : 32'd8);
      chk($sformatf("starve_data_c%0d", k), in_reg, (k == 4) ? 32'hAAAA0003 : 32'(k));
    end
    alu_valid = 1'b0;
    tick();

    // Fill the FIFO with r4..r7 while the ALU is busy, then drain it in order.
    for (int k = 1; k <= 4; k++) begin
      alu_valid = 1'b1; alu_sel = 4'd8; alu_data = 32'h100 + 32'(k);
      ld_valid = 1'b1; ld_sel = 4'(3 + k); ld_data = 32'h40000000 + 32'(k);
      #1;
      chk($sformatf("fill_ld_ready_%0d", k), 32'(ld_ready), 32'd1);
      chk($sformatf("fill_stall_%0d", k), 32'(alu_stall), 32'd0);
      tick();
      chk($sformatf("fill_sel_%0d", k), 32'(sel_in), 32'd8);
    end
    alu_valid = 1'b0; ld_valid = 1'b0; hz_sel = 4'd7;
    #1;
    chk("full_ld_ready", 32'(ld_ready), 32'd0);
    chk("full_stall", 32'(alu_stall), 32'd1);
    chk("full_hz_r7", 32'(hz_pending), 32'd1);
    tick();
    chk("drain_sel_1", 32'(sel_in), 32'd4);
    chk("drain_data_1", in_reg, 32'h40000001);
    for (int j = 2; j <= 4; j++) begin
      chk($sformatf("drain_ld_ready_%0d", j), 32'(ld_ready), 32'd1);
      tick();
      chk($sformatf("drain_en_%0d", j), 32'(in_enable), 32'd1);
      chk($sformatf("drain_sel_%0d", j), 32'(sel_in), 32'(3 + j));
      chk($sformatf("drain_data_%0d", j), in_reg, 32'h40000000 + 32'(j));
    end
    tick();
    chk("drain_done_en", 32'(in_enable), 32'd0);
    chk("drain_done_hz", 32'(hz_pending), 32'd0);

    // PC write pulse and flag update/hold.
    alu_valid = 1'b1; alu_sel = 4'hF; alu_data = 32'h00000100;
    alu_flags_we = 1'b1; alu_flags = 4'b1100;
    tick();
    alu_valid = 1'b0; alu_flags_we = 1'b0; alu_flags = 4'b0011;
    chk("pc_sel_in", 32'(sel_in), 32'hF);
    chk("pc_written_pulse", 32'(pc_written), 32'd1);
    chk("flags_set", 32'(flags_in), 32'hC);
    tick();
    chk("pc_written_clear", 32'(pc_written), 32'd0);
    chk("flags_hold", 32'(flags_in), 32'hC);
    alu_flags_we = 1'b1; alu_flags = 4'b0101;
    tick();
    alu_flags_we = 1'b0;
    chk("flags_no_alu", 32'(flags_in), 32'h5);
    chk("flags_no_alu_en", 32'(in_enable), 32'd0);

    // Reset with three loads queued.
    for (int k = 1; k <= 3; k++) begin
      alu_valid = 1'b1; alu_sel = 4'd8; alu_data = 32'h200 + 32'(k);
      ld_valid = 1'b1; ld_sel = 4'(k); ld_data = 32'h50000000 + 32'(k);
      tick();
    end
    alu_valid = 1'b0; ld_valid = 1'b0; hz_sel = 4'd2;
    #1;
    chk("pre_rst_hz", 32'(hz_pending), 32'd1);
    chk("pre_rst_en", 32'(in_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(in_enable), 32'd0);
    chk("mid_rst_sel", 32'(sel_in), 32'd0);
    chk("mid_rst_reg", in_reg, 32'd0);
    chk("mid_rst_flags", 32'(flags_in), 32'd0);
    chk("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("mid_rst_hz", 32'(hz_pending), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("post_rst_en_%0d", k), 32'(in_enable), 32'd0);
      chk($sformatf("post_rst_stall_%0d", k), 32'(alu_stall), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
